// File: rtl/morse_decoder.sv
// morse_decoder: receive side of the Morse lab.
// Samples the light stream on each rate-divider tick, measures mark and space
// run lengths, assembles dots/dashes into a symbol register and, once a full
// letter gap has been seen, decodes the letter select code (S..Z -> 0..7).
module morse_decoder #(
   parameter int CNT_W      = 3,  // mark/space run counter width (saturating)
   parameter int DASH_LEN   = 3,  // mark length (ticks) of a dash; a dot is 1
   parameter int LETTER_GAP = 3,  // space length (ticks) that ends a letter
   parameter int MAX_SYM    = 4   // most dots/dashes allowed in one letter
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       serial_in,
   output logic [2:0] letter,
   output logic       letter_valid,
   output logic       letter_error,
   output logic       busy
);

   localparam int NSYM_W = $clog2(MAX_SYM + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MARK,
      ST_SPACE
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_mark_cnt;
   logic [CNT_W-1:0]    r_space_cnt;
   logic [MAX_SYM-1:0]  r_sym;       // dot=0, dash=1, newest symbol at LSB
   logic [NSYM_W-1:0]   r_nsym;
   logic                r_bad;       // sticky: something malformed in this letter
   logic [2:0]          r_letter;
   logic                r_valid;
   logic                r_error;

   logic                w_mark_is_dot;
   logic                w_mark_is_dash;
   logic                w_sym_full;
   logic [CNT_W-1:0]    w_space_next;
   logic                w_gap_done;
   logic                w_dec_ok;
   logic [2:0]          w_dec_code;

   assign w_mark_is_dot  = (r_mark_cnt == CNT_W'(1));
   assign w_mark_is_dash = (r_mark_cnt == CNT_W'(DASH_LEN));
   assign w_sym_full     = (r_nsym == NSYM_W'(MAX_SYM));
   assign w_space_next   = r_space_cnt + CNT_W'(1);
   assign w_gap_done     = (w_space_next == CNT_W'(LETTER_GAP));

   // Map the collected symbols to a letter code; anything unlisted is an error.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_dec_ok   = 1'b1;
      w_dec_code = 3'd0;
      if (r_bad) begin
         w_dec_ok = 1'b0;
      end else if (r_nsym == NSYM_W'(3) && r_sym == MAX_SYM'(4'b0000)) begin
         w_dec_code = 3'd0;   // S ...
      end else if (r_nsym == NSYM_W'(1) && r_sym == MAX_SYM'(4'b0001)) begin
         w_dec_code = 3'd1;   // T -
      end else if (r_nsym == NSYM_W'(3) && r_sym == MAX_SYM'(4'b0001)) begin
         w_dec_code = 3'd2;   // U ..-
      end else if (r_nsym == NSYM_W'(4) && r_sym == MAX_SYM'(4'b0001)) begin
         w_dec_code = 3'd3;   // V ...-
      end else if (r_nsym == NSYM_W'(3) && r_sym == MAX_SYM'(4'b0011)) begin
         w_dec_code = 3'd4;   // W .--
      end else if (r_nsym == NSYM_W'(4) && r_sym == MAX_SYM'(4'b1001)) begin
         w_dec_code = 3'd5;   // X -..-
      end else if (r_nsym == NSYM_W'(4) && r_sym == MAX_SYM'(4'b1011)) begin
         w_dec_code = 3'd6;   // Y -.--
      end else if (r_nsym == NSYM_W'(4) && r_sym == MAX_SYM'(4'b1100)) begin
         w_dec_code = 3'd7;   // Z --..
      end else begin
         w_dec_ok = 1'b0;
      end
   end

   // Run-length FSM advanced on each tick; result pulses are registered here too.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_mark_cnt  <= '0;
         r_space_cnt <= '0;
         r_sym       <= '0;
         r_nsym      <= '0;
         r_bad       <= 1'b0;
         r_letter    <= 3'd0;
         r_valid     <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         r_valid <= 1'b0;
         r_error <= 1'b0;
         if (tick) begin
            case (r_state)
               ST_IDLE: begin
                  if (serial_in) begin
                     r_state    <= ST_MARK;
                     r_mark_cnt <= CNT_W'(1);
                  end
               end
               ST_MARK: begin
                  if (serial_in) begin
                     // Saturate so an over-long mark can never wrap back to a dot.
                     if (r_mark_cnt != '1) begin
                        r_mark_cnt <= r_mark_cnt + CNT_W'(1);
                     end
                  end else begin
                     if (w_sym_full) begin
                        r_bad <= 1'b1;
                     end else if (w_mark_is_dot || w_mark_is_dash) begin
                        r_sym  <= {r_sym[MAX_SYM-2:0], w_mark_is_dash};
                        r_nsym <= r_nsym + NSYM_W'(1);
                     end else begin
                        r_bad <= 1'b1;
                     end
                     r_state     <= ST_SPACE;
                     r_space_cnt <= CNT_W'(1);
                  end
               end
               ST_SPACE: begin
                  if (serial_in) begin
                     // Only a single-unit gap is legal between symbols.
                     if (r_space_cnt != CNT_W'(1)) begin
                        r_bad <= 1'b1;
                     end
                     r_state    <= ST_MARK;
                     r_mark_cnt <= CNT_W'(1);
                  end else if (w_gap_done) begin
                     r_valid <= w_dec_ok;
                     r_error <= !w_dec_ok;
                     if (w_dec_ok) begin
                        r_letter <= w_dec_code;
                     end
                     r_state     <= ST_IDLE;
                     r_mark_cnt  <= '0;
                     r_space_cnt <= '0;
                     r_sym       <= '0;
                     r_nsym      <= '0;
                     r_bad       <= 1'b0;
                  end else begin
                     r_space_cnt <= w_space_next;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign letter       = r_letter;
   assign letter_valid = r_valid;
   assign letter_error = r_error;
   assign busy         = (r_state != ST_IDLE);

endmodule
